// File: rtl/branch_sequencer.sv
// Branch sequencer: drives Ra to the CON FF, samples the condition and commits the next PC.
// Optional BRANCH_STATS_EN adds saturating taken / not-taken commit counters.
module branch_sequencer #(
  parameter int          WIDTH     = 32,
  parameter int          OFFSET_W  = 19,
  parameter logic [4:0]  BR_OPCODE = 5'b10010
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] ir,
  input  logic [WIDTH-1:0] ra_value,
  input  logic [WIDTH-1:0] pc_in,
  input  logic             con_ff,
  output logic [WIDTH-1:0] bus_out,
  output logic             con_in,
  output logic [1:0]       cond_sel,
  output logic [WIDTH-1:0] pc_out,
  output logic             pc_load,
  output logic             taken,
  output logic             busy,
  output logic             done,
`ifdef BRANCH_STATS_EN
  output logic [15:0]      taken_count,
  output logic [15:0]      nottaken_count,
`endif
  output logic             err
);

  typedef enum logic [1:0] {IDLE, EVAL, SAMPLE, COMMIT} state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    ra_q, ra_d;
  logic [WIDTH-1:0]    pc_q, pc_d;
  logic [WIDTH-1:0]    target_q, target_d;
  logic [OFFSET_W-1:0] off_q, off_d;
  logic [1:0]          cond_q, cond_d;
  logic                bad_q, bad_d;
  logic                taken_q, taken_d;
  logic [WIDTH-1:0]    off_sext;
  logic                unused_ir;

  // Only opcode, condition and offset fields of IR matter here.
  assign unused_ir = ^ir;
  assign off_sext  = {{(WIDTH-OFFSET_W){off_q[OFFSET_W-1]}}, off_q};

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q  <= IDLE;
      ra_q     <= '0;
      pc_q     <= '0;
      target_q <= '0;
      off_q    <= '0;
      cond_q   <= '0;
      bad_q    <= 1'b0;
      taken_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ra_q     <= ra_d;
      pc_q     <= pc_d;
      target_q <= target_d;
      off_q    <= off_d;
      cond_q   <= cond_d;
      bad_q    <= bad_d;
      taken_q  <= taken_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ra_d     = ra_q;
    pc_d     = pc_q;
    target_d = target_q;
    off_d    = off_q;
    cond_d   = cond_q;
    bad_d    = bad_q;
    taken_d  = taken_q;
    bus_out  = '0;
    con_in   = 1'b0;
    pc_out   = '0;
    pc_load  = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    busy     = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (start) begin
          ra_d    = ra_value;
          pc_d    = pc_in;
          off_d   = ir[OFFSET_W-1:0];
          cond_d  = ir[20:19];
          taken_d = 1'b0;
          bad_d   = (ir[31:27] != BR_OPCODE);
          state_d = (ir[31:27] != BR_OPCODE) ? COMMIT : EVAL;
        end
      end
      EVAL: begin
        con_in  = 1'b1;
        bus_out = ra_q;
        state_d = SAMPLE;
      end
      SAMPLE: begin
        taken_d  = con_ff;
        target_d = pc_q + off_sext;
        state_d  = COMMIT;
      end
      COMMIT: begin
        pc_load = 1'b1;
        done    = 1'b1;
        err     = bad_q;
        // taken_q stays 0 for a bad opcode, so the PC is passed through.
        pc_out  = (taken_q && !bad_q) ? target_q : pc_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cond_sel = cond_q;
  assign taken    = taken_q;

`ifdef BRANCH_STATS_EN
  logic [15:0] taken_cnt_q, nottaken_cnt_q;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      taken_cnt_q    <= '0;
      nottaken_cnt_q <= '0;
    end else if (state_q == COMMIT && !bad_q) begin
      if (taken_q && taken_cnt_q != 16'hFFFF)
        taken_cnt_q <= taken_cnt_q + 16'd1;
      if (!taken_q && nottaken_cnt_q != 16'hFFFF)
        nottaken_cnt_q <= nottaken_cnt_q + 16'd1;
    end
  end

  assign taken_count    = taken_cnt_q;
  assign nottaken_count = nottaken_cnt_q;
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench for branch_sequencer: directed table, random ops vs. a
// PC-arithmetic reference model, busy/clear sequences, optional stats counters.
module tb_branch_sequencer;
  localparam logic [4:0] BR = 5'b10010;

  logic        clk, clear, start, con_ff;
  logic [31:0] ir, ra_value, pc_in;
  logic [31:0] bus_out, pc_out;
  logic [1:0]  cond_sel;
  logic        con_in, pc_load, taken, busy, done, err;
`ifdef BRANCH_STATS_EN
  logic [15:0] taken_count, nottaken_count;
`endif

  int nvec = 0, nerr = 0;
  int m_tc = 0, m_nc = 0;

  branch_sequencer dut (
    .clk(clk), .clear(clear), .start(start), .ir(ir), .ra_value(ra_value),
    .pc_in(pc_in), .con_ff(con_ff), .bus_out(bus_out), .con_in(con_in),
    .cond_sel(cond_sel), .pc_out(pc_out), .pc_load(pc_load), .taken(taken),
    .busy(busy), .done(done),
`ifdef BRANCH_STATS_EN
    .taken_count(taken_count), .nottaken_count(nottaken_count),
`endif
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] ir, ra, pc;
    logic        cf;
    logic [31:0] e_pc;
    logic        e_tk, e_err;
  } vec_t;

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [1:0] cond,
                                        input logic [18:0] c);
    return {op, 4'd2, 2'b00, cond, c};
  endfunction

  // Reference: next PC from plain signed arithmetic on the 19-bit offset.
  function automatic logic [31:0] model_pc(input logic [31:0] i, input logic [31:0] pc,
                                           input logic cf);
    longint off;
    if (i[31:27] != BR || !cf) return pc;
    off = longint'(i[18:0]);
    if (off >= 262144) off = off - 524288;
    return 32'(longint'(pc) + off);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic run_op(input string nm, input logic [31:0] ir_v, input logic [31:0] ra_v,
                        input logic [31:0] pc_v, input logic cf, input logic [31:0] e_pc,
                        input logic e_tk, input logic e_err);
    int  k, ncon;
    bit  seen;
    @(negedge clk);
    ir = ir_v; ra_value = ra_v; pc_in = pc_v; start = 1'b1; con_ff = ~cf;
    @(posedge clk);
    #1 start = 1'b0;
    ir = $urandom; ra_value = $urandom; pc_in = $urandom;
    k = 0; ncon = 0; seen = 0;
    while (!seen && k < 8) begin
      @(negedge clk);
      k++;
      con_ff = (k == 2) ? cf : ~cf;
      if (con_in) begin
        ncon++;
        chk({nm, " bus_out"}, bus_out, ra_v);
        chk({nm, " cond_sel"}, 32'(cond_sel), 32'(ir_v[20:19]));
      end
      if (done) begin
        seen = 1;
        chk({nm, " latency"}, k, e_err ? 1 : 3);
        chk({nm, " pc_out"}, pc_out, e_pc);
        chk({nm, " pc_load/taken/err"}, {29'd0, pc_load, taken, err}, {29'd0, 1'b1, e_tk, e_err});
      end
    end
    if (!seen) chk({nm, " done timeout"}, 32'd0, 32'd1);
    chk({nm, " con_in cycles"}, ncon, e_err ? 0 : 1);
    @(negedge clk);
    chk({nm, " after busy/done/taken"}, {29'd0, busy, done, taken}, {29'd0, 1'b0, 1'b0, e_tk});
    if (!e_err) begin
      if (e_tk) m_tc = (m_tc == 65535) ? 65535 : m_tc + 1;
      else      m_nc = (m_nc == 65535) ? 65535 : m_nc + 1;
    end
  endtask

  task automatic pulse_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    m_tc = 0; m_nc = 0;
  endtask

  vec_t vt[8];

  initial begin
    int ndone, con2;
    logic [31:0] pcs[2];

    vt[0] = '{mk_ir(BR, 2'b00, 19'd8),        32'h0,        32'h20,       1'b1, 32'h28,       1'b1, 1'b0};
    vt[1] = '{mk_ir(BR, 2'b01, 19'h7FFFC),    32'h0,        32'h40,       1'b0, 32'h40,       1'b0, 1'b0};
    vt[2] = '{mk_ir(BR, 2'b01, 19'h7FFFC),    32'h0,        32'h40,       1'b1, 32'h3C,       1'b1, 1'b0};
    vt[3] = '{{5'b00011, 27'h0123456},        32'h5,        32'h100,      1'b1, 32'h100,      1'b0, 1'b1};
    vt[4] = '{mk_ir(BR, 2'b10, 19'h3FFFF),    32'h7,        32'h0,        1'b1, 32'h3FFFF,    1'b1, 1'b0};
    vt[5] = '{mk_ir(BR, 2'b11, 19'h40000),    32'h9,        32'h100000,   1'b1, 32'hC0000,    1'b1, 1'b0};
    vt[6] = '{mk_ir(BR, 2'b00, 19'h7FFE0),    32'h0,        32'h10,       1'b1, 32'hFFFFFFF0, 1'b1, 1'b0};
    vt[7] = '{mk_ir(BR, 2'b11, 19'h10),       32'hDEADBEEF, 32'hFFFFFFF8, 1'b1, 32'h8,        1'b1, 1'b0};

    clear = 1'b1; start = 1'b0; con_ff = 1'b0; ir = '0; ra_value = '0; pc_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset outputs", {bus_out, pc_out}, 64'd0);
    chk("reset flags", {24'd0, cond_sel, con_in, pc_load, taken, busy, done, err}, 32'd0);
    clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle quiet", {26'd0, con_in, pc_load, busy, done, err, taken}, 32'd0);
    end

    foreach (vt[i])
      run_op($sformatf("vec%0d", i), vt[i].ir, vt[i].ra, vt[i].pc, vt[i].cf,
             vt[i].e_pc, vt[i].e_tk, vt[i].e_err);

    for (int i = 0; i < 20; i++) begin
      logic [4:0]  op;
      logic [31:0] iv, pv;
      logic        cf;
      op = ($urandom_range(0, 3) == 0) ? 5'($urandom) : BR;
      iv = {op, 27'($urandom)};
      pv = $urandom;
      cf = 1'($urandom_range(0, 1));
      run_op($sformatf("rnd%0d", i), iv, $urandom, pv, cf, model_pc(iv, pv, cf),
             (op == BR) && cf, op != BR);
    end

    // start held for 6 edges: branches accepted at edge 0 and edge 4 only.
    @(negedge clk);
    ir = mk_ir(BR, 2'b00, 19'd4); ra_value = 32'h5; pc_in = 32'h1000; start = 1'b1; con_ff = 1'b1;
    ndone = 0; con2 = 0; pcs[0] = '0; pcs[1] = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) pc_in = 32'h2000;
      if (c == 6) start = 1'b0;
      if (con_in && c > 1 && con2 == 0) con2 = c;
      if (done) begin
        if (ndone < 2) pcs[ndone] = pc_out;
        ndone++;
      end
    end
    chk("busy: branches run", ndone, 2);
    chk("busy: second EVAL cycle", con2, 5);
    chk("busy: first pc_out", pcs[0], 32'h1004);
    chk("busy: second pc_out", pcs[1], 32'h2004);

    // clear during EVAL aborts without any commit.
    @(negedge clk);
    ir = mk_ir(BR, 2'b00, 19'd4); pc_in = 32'h3000; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("abort: in EVAL", {31'd0, con_in}, 32'd1);
    clear = 1'b1;
    #1;
    chk("abort: async drop", {29'd0, con_in, busy, pc_load}, 32'd0);
    @(negedge clk); clear = 1'b0;
    m_tc = 0; m_nc = 0;
    ndone = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (pc_load || done || busy) ndone++;
    end
    chk("abort: no commit", ndone, 0);

`ifdef BRANCH_STATS_EN
    pulse_clear();
    chk("stats reset", {taken_count, nottaken_count}, 32'd0);
    for (int i = 0; i < 3; i++)
      run_op("stat_t", mk_ir(BR, 2'b00, 19'd1), 32'h0, 32'h50, 1'b1, 32'h51, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++)
      run_op("stat_n", mk_ir(BR, 2'b00, 19'd1), 32'h0, 32'h50, 1'b0, 32'h50, 1'b0, 1'b0);
    run_op("stat_bad", {5'b00001, 27'h0}, 32'h0, 32'h60, 1'b1, 32'h60, 1'b0, 1'b1);
    chk("taken_count", 32'(taken_count), m_tc);
    chk("nottaken_count", 32'(nottaken_count), m_nc);
    @(negedge clk);
    force dut.taken_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.taken_cnt_q;
    run_op("stat_sat", mk_ir(BR, 2'b00, 19'd1), 32'h0, 32'h50, 1'b1, 32'h51, 1'b1, 1'b0);
    chk("taken_count saturate", 32'(taken_count), 32'hFFFF);
    chk("nottaken_count hold", 32'(nottaken_count), m_nc);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
